// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: accepts one load/store, waits WAIT_CYCLES,
// performs the access, then holds the response until the CPU consumes it.
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DEPTH_P = DEPTH;
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH_P[ADDR_W:0];
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_reg;
  logic [3:0]          cnt_reg;
  logic                lat_we_reg;
  logic [ADDR_W-1:0]   lat_addr_reg;
  logic [DATA_W-1:0]   lat_wdata_reg;
  logic                req_ready_reg;
  logic                rsp_valid_reg;
  logic [DATA_W-1:0]   rsp_rdata_reg;
  logic                rsp_err_reg;
  logic                busy_reg;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                do_access;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic                in_range;
  logic [IDX_W-1:0]    acc_idx;

  assign accept = req_valid && req_ready_reg;

  // With zero wait states the access happens on the accept edge itself, so it
  // must use the live request rather than the not-yet-latched copy.
  always_comb begin
    acc_we    = lat_we_reg;
    acc_addr  = lat_addr_reg;
    acc_wdata = lat_wdata_reg;
    do_access = 1'b0;
    if (state_reg == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      do_access = accept && (WAIT_CYCLES == 0);
    end else if (state_reg == S_WAIT) begin
      do_access = (cnt_reg == 4'd0);
    end
  end

  assign in_range = ({1'b0, acc_addr} < DEPTH_LIM);
  assign acc_idx  = acc_addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      lat_we_reg    <= 1'b0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            lat_we_reg    <= req_we;
            lat_addr_reg  <= req_addr;
            lat_wdata_reg <= req_wdata;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            cnt_reg       <= CNT_INIT;
            state_reg     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_reg     <= S_IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
      // Access result overrides the WAIT transition taken above on the same edge.
      if (do_access) begin
        state_reg     <= S_RESP;
        rsp_valid_reg <= 1'b1;
        rsp_err_reg   <= !in_range;
        rsp_rdata_reg <= (in_range && !acc_we) ? mem[acc_idx] : '0;
      end
    end
  end

  // Memory contents survive reset; rst only blocks a zero-wait store racing it.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && in_range && !rst) mem[acc_idx] <= acc_wdata;
  end

  assign req_ready = req_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance with two wait states, one with none,
// checked against an array-based memory model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr, req_wdata;

  logic        a_ready, a_valid, a_err, a_busy;
  logic [15:0] a_rdata;
  logic        z_ready, z_valid, z_err, z_busy;
  logic [15:0] z_rdata;

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(a_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_valid), .rsp_ready(rsp_ready), .rsp_rdata(a_rdata),
    .rsp_err(a_err), .busy(a_busy)
  );

  dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(z_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(z_valid), .rsp_ready(rsp_ready), .rsp_rdata(z_rdata),
    .rsp_err(z_err), .busy(z_busy)
  );

  logic        cur_ready, cur_valid, cur_err, cur_busy;
  logic [15:0] cur_rdata;
  assign cur_ready = sel ? z_ready : a_ready;
  assign cur_valid = sel ? z_valid : a_valid;
  assign cur_err   = sel ? z_err   : a_err;
  assign cur_busy  = sel ? z_busy  : a_busy;
  assign cur_rdata = sel ? z_rdata : a_rdata;

  logic [15:0] mdl_mem   [2][256];
  bit          mdl_known [2][256];
  int checks = 0;
  int errors = 0;

  function automatic int exp_lat();
    return sel ? 0 : 2;
  endfunction

  // Reference behaviour: range check on the full address, stores commit, loads read.
  task automatic model(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       output logic [15:0] er, output logic ee, output bit known);
    int s;
    s = sel ? 1 : 0;
    if (addr >= 16'd256) begin
      ee = 1'b1; er = 16'h0; known = 1'b1;
    end else if (we) begin
      ee = 1'b0; er = 16'h0; known = 1'b1;
      mdl_mem[s][addr[7:0]] = wd;
      mdl_known[s][addr[7:0]] = 1'b1;
    end else begin
      ee = 1'b0; er = mdl_mem[s][addr[7:0]]; known = mdl_known[s][addr[7:0]];
    end
  endtask

  // Drive a request, wait for the accept edge, then count edges until rsp_valid.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       output int acc_cyc, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
    n = 0;
    while (!cur_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    lat = 0;
    while (!cur_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!cur_valid) lat = -1;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int ac, lat;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0 || a_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b valid=%b busy=%b err=%b rdata=%h, expected 1 0 0 0 0000",
               a_ready, a_valid, a_busy, a_err, a_rdata);
    end
    $display("reset released: ready=%b valid=%b busy=%b", a_ready, a_valid, a_busy);
    issue(1'b1, 16'd20, 16'hA5A5, ac, lat);
    mdl_mem[0][20] = 16'hA5A5; mdl_known[0][20] = 1'b1;
    #2 rst = 1'b1; #1;
    checks++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0 || a_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: ready=%b valid=%b busy=%b err=%b rdata=%h, expected 1 0 0 0 0000",
               a_ready, a_valid, a_busy, a_err, a_rdata);
    end
    $display("async reset in RESP: valid=%b busy=%b", a_valid, a_busy);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_store_load();
    int ac, lat;
    logic [15:0] er; logic ee; bit kn;
    sel = 1'b0;
    issue(1'b1, 16'd5, 16'hBEEF, ac, lat);
    model(1'b1, 16'd5, 16'hBEEF, er, ee, kn);
    checks++;
    if (lat !== exp_lat() || cur_rdata !== er || cur_err !== ee) begin
      errors++;
      $display("FAIL store5: lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
               lat, cur_rdata, cur_err, exp_lat(), er, ee);
    end
    $display("store addr=5 data=BEEF lat=%0d err=%b", lat, cur_err);
    finish_rsp();
    for (int i = 0; i < 2; i++) begin
      logic [15:0] a;
      a = (i == 0) ? 16'd5 : 16'd20;
      issue(1'b0, a, 16'h0, ac, lat);
      model(1'b0, a, 16'h0, er, ee, kn);
      checks++;
      if (lat !== exp_lat() || cur_rdata !== er || cur_err !== ee) begin
        errors++;
        $display("FAIL load%0d: lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                 a, lat, cur_rdata, cur_err, exp_lat(), er, ee);
      end
      $display("load addr=%0d rdata=%h lat=%0d", a, cur_rdata, lat);
      finish_rsp();
    end
  endtask

  task automatic test_backpressure();
    int ac, lat;
    logic [15:0] er; logic ee; bit kn;
    sel = 1'b0;
    issue(1'b0, 16'd5, 16'h0, ac, lat);
    model(1'b0, 16'd5, 16'h0, er, ee, kn);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'hDEAD;
      @(posedge clk); #1;
      checks++;
      if (cur_valid !== 1'b1 || cur_rdata !== er || cur_ready !== 1'b0 || cur_busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: valid=%b rdata=%h ready=%b busy=%b, expected 1 %h 0 1",
                 i, cur_valid, cur_rdata, cur_ready, cur_busy, er);
      end
    end
    req_valid = 1'b0;
    finish_rsp();
    checks++;
    if (cur_valid !== 1'b0 || cur_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b ready=%b, expected 0 1", cur_valid, cur_ready);
    end
    $display("backpressure load addr=5 rdata=%h released", er);
    issue(1'b0, 16'd5, 16'h0, ac, lat);
    model(1'b0, 16'd5, 16'h0, er, ee, kn);
    checks++;
    if (cur_rdata !== er || cur_err !== ee) begin
      errors++;
      $display("FAIL backpressure_ignored_store: rdata=%h, expected %h", cur_rdata, er);
    end
    finish_rsp();
  endtask

  task automatic test_out_of_range();
    int ac, lat;
    logic [15:0] er; logic ee; bit kn;
    logic [15:0] addrs [3];
    logic        wes   [3];
    logic [15:0] wds   [3];
    sel = 1'b0;
    addrs = '{16'h0000, 16'h0100, 16'h0000};
    wes   = '{1'b1, 1'b1, 1'b0};
    wds   = '{16'h7777, 16'h1234, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      issue(wes[i], addrs[i], wds[i], ac, lat);
      model(wes[i], addrs[i], wds[i], er, ee, kn);
      checks++;
      if (lat !== exp_lat() || cur_rdata !== er || cur_err !== ee) begin
        errors++;
        $display("FAIL oor_step%0d: lat=%0d rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                 i, lat, cur_rdata, cur_err, exp_lat(), er, ee);
      end
      $display("we=%b addr=%h rdata=%h err=%b", wes[i], addrs[i], cur_rdata, cur_err);
      finish_rsp();
    end
  endtask

  task automatic test_zero_wait();
    int ac, lat, prev_ac;
    logic [15:0] er; logic ee; bit kn;
    sel = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      issue(1'b1, 16'(i), 16'(16'h1100 + i), ac, lat);
      model(1'b1, 16'(i), 16'(16'h1100 + i), er, ee, kn);
      finish_rsp();
    end
    prev_ac = 0;
    for (int i = 1; i <= 2; i++) begin
      issue(1'b0, 16'(i), 16'h0, ac, lat);
      model(1'b0, 16'(i), 16'h0, er, ee, kn);
      checks++;
      if (lat !== 0 || cur_rdata !== er || cur_err !== ee) begin
        errors++;
        $display("FAIL zero_wait_load%0d: lat=%0d rdata=%h err=%b, expected lat=0 rdata=%h err=%b",
                 i, lat, cur_rdata, cur_err, er, ee);
      end
      if (i == 2) begin
        checks++;
        if (ac - prev_ac !== 2) begin
          errors++;
          $display("FAIL zero_wait_spacing: accept gap=%0d, expected 2", ac - prev_ac);
        end
      end
      $display("zero-wait load addr=%0d rdata=%h accept_cyc=%0d", i, cur_rdata, ac);
      prev_ac = ac;
      finish_rsp();
    end
  endtask

  task automatic test_reset_wait();
    int ac, lat;
    logic [15:0] er; logic ee; bit kn;
    sel = 1'b0;
    issue(1'b1, 16'd9, 16'h3C3C, ac, lat);
    model(1'b1, 16'd9, 16'h3C3C, er, ee, kn);
    finish_rsp();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd9; req_wdata = 16'h5555; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (cur_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait_accept: busy=%b, expected 1", cur_busy);
    end
    @(posedge clk); #2 rst = 1'b1; #1;
    checks++;
    if (cur_busy !== 1'b0 || cur_ready !== 1'b1 || cur_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_clear: busy=%b ready=%b valid=%b, expected 0 1 0", cur_busy, cur_ready, cur_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cur_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_wait_no_rsp%0d: valid=%b, expected 0", i, cur_valid);
      end
    end
    issue(1'b0, 16'd9, 16'h0, ac, lat);
    model(1'b0, 16'd9, 16'h0, er, ee, kn);
    checks++;
    if (cur_rdata !== er || cur_err !== ee) begin
      errors++;
      $display("FAIL reset_wait_mem: rdata=%h, expected %h", cur_rdata, er);
    end
    $display("store 5555 abandoned in WAIT, addr 9 reads %h", cur_rdata);
    finish_rsp();
  endtask

  task automatic test_random();
    int ac, lat, hold;
    logic we;
    logic [15:0] addr, wd, er;
    logic ee; bit kn;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      for (int t = 0; t < 40; t++) begin
        we   = 1'($urandom);
        addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
        wd   = 16'($urandom);
        hold = $urandom_range(0, 3);
        issue(we, addr, wd, ac, lat);
        model(we, addr, wd, er, ee, kn);
        repeat (hold) begin @(posedge clk); #1; end
        checks++;
        if (lat !== exp_lat() || cur_valid !== 1'b1 || cur_err !== ee || (kn && cur_rdata !== er)) begin
          errors++;
          $display("FAIL random%0d_%0d: we=%b addr=%h lat=%0d valid=%b rdata=%h err=%b, expected lat=%0d rdata=%h err=%b",
                   s, t, we, addr, lat, cur_valid, cur_rdata, cur_err, exp_lat(), er, ee);
        end
        $display("rand sel=%0d we=%b addr=%h wdata=%h rdata=%h err=%b lat=%0d",
                 s, we, addr, wd, cur_rdata, cur_err, lat);
        finish_rsp();
      end
    end
  endtask

  initial begin
    sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 16'h0; rsp_ready = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++) begin
        mdl_mem[s][a] = 16'h0;
        mdl_known[s][a] = 1'b0;
      end
    test_reset();
    test_store_load();
    test_backpressure();
    test_out_of_range();
    test_zero_wait();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
